// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both stages reset to the idle-high level.
module rx_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= D;
      sync_reg <= meta_reg;
    end
  end

  assign Q = sync_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receive controller: finds the start bit, samples each bit at its centre and
// hands data bits one at a time to a downstream shift register, then flags stop-bit status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BAUD_TICK,
  input  logic RX,
  output logic BIT_OUT,
  output logic BIT_STB,
  output logic RX_DONE,
  output logic FRAME_ERR,
  output logic BUSY
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic              rxs;
  logic              rxs_d_reg;
  logic              fall_edge;

  uart_state_t       state_reg,     state_next;
  logic [TICK_W-1:0] tick_reg,      tick_next;
  logic [BIT_W-1:0]  bit_reg,       bit_next;
  logic              bit_out_reg,   bit_out_next;
  logic              bit_stb_reg,   bit_stb_next;
  logic              rx_done_reg,   rx_done_next;
  logic              frame_err_reg, frame_err_next;

  rx_sync u_rx_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (RX),
    .Q     (rxs)
  );

  // A held-low line never looks like an edge, so a stuck or erroring line cannot retrigger.
  assign fall_edge = rxs_d_reg & ~rxs;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rxs_d_reg     <= 1'b1;
      state_reg     <= IDLE;
      tick_reg      <= '0;
      bit_reg       <= '0;
      bit_out_reg   <= 1'b0;
      bit_stb_reg   <= 1'b0;
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rxs_d_reg     <= rxs;
      state_reg     <= state_next;
      tick_reg      <= tick_next;
      bit_reg       <= bit_next;
      bit_out_reg   <= bit_out_next;
      bit_stb_reg   <= bit_stb_next;
      rx_done_reg   <= rx_done_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tick_next      = tick_reg;
    bit_next       = bit_reg;
    bit_out_next   = bit_out_reg;
    bit_stb_next   = 1'b0;
    rx_done_next   = 1'b0;
    frame_err_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (fall_edge) begin
          state_next = START;
          tick_next  = '0;
          bit_next   = '0;
        end
      end

      START: begin
        if (BAUD_TICK) begin
          if (tick_reg == HALF_LAST) begin
            tick_next  = '0;
            // Line back high at mid start bit is a glitch: drop it silently.
            state_next = rxs ? IDLE : DATA;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end

      DATA: begin
        if (BAUD_TICK) begin
          if (tick_reg == FULL_LAST) begin
            tick_next    = '0;
            bit_out_next = rxs;
            bit_stb_next = 1'b1;
            if (bit_reg == BIT_LAST) begin
              bit_next   = '0;
              state_next = STOP;
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end

      STOP: begin
        if (BAUD_TICK) begin
          if (tick_reg == FULL_LAST) begin
            tick_next      = '0;
            rx_done_next   = rxs;
            frame_err_next = ~rxs;
            state_next     = IDLE;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        tick_next  = '0;
        bit_next   = '0;
      end
    endcase
  end

  assign BIT_OUT   = bit_out_reg;
  assign BIT_STB   = bit_stb_reg;
  assign RX_DONE   = rx_done_reg;
  assign FRAME_ERR = frame_err_reg;
  assign BUSY      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: drives serial frames in baud-tick units and compares the
// received bit stream and completion pulses against frame-level expectations.
module tb_uart_rx_ctrl;

  localparam int DB = 8;
  localparam int OS = 16;

  logic CLK = 1'b0;
  logic RST_N;
  logic BAUD_TICK;
  logic RX;
  logic BIT_OUT;
  logic BIT_STB;
  logic RX_DONE;
  logic FRAME_ERR;
  logic BUSY;

  int   checks   = 0;
  int   failures = 0;

  logic tick_en;
  int   tick_div;

  logic got_bits[$];
  int   done_cnt  = 0;
  int   err_cnt   = 0;
  int   both_cnt  = 0;
  int   busy_cyc  = 0;

  uart_rx_ctrl #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .BAUD_TICK (BAUD_TICK),
    .RX        (RX),
    .BIT_OUT   (BIT_OUT),
    .BIT_STB   (BIT_STB),
    .RX_DONE   (RX_DONE),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  // Baud tick every 4 clocks, can be gated off.
  initial begin
    BAUD_TICK = 1'b0;
    tick_div  = 0;
    forever begin
      @(negedge CLK);
      tick_div  = (tick_div + 1) % 4;
      BAUD_TICK = tick_en && (tick_div == 0);
    end
  end

  always @(negedge CLK) begin
    if (BIT_STB === 1'b1) got_bits.push_back(BIT_OUT);
    if (RX_DONE === 1'b1) done_cnt <= done_cnt + 1;
    if (FRAME_ERR === 1'b1) err_cnt <= err_cnt + 1;
    if (RX_DONE === 1'b1 && FRAME_ERR === 1'b1) both_cnt <= both_cnt + 1;
    if (BUSY === 1'b1) busy_cyc <= busy_cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge CLK);
      if (BAUD_TICK) k++;
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic end_level);
    RX = 1'b0;
    hold_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      RX = data[i];
      hold_ticks(OS);
    end
    RX = stop;
    hold_ticks(OS);
    RX = end_level;
  endtask

  task automatic test_reset;
    RST_N   = 1'b0;
    RX      = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++; if (BIT_STB !== 1'b0)   begin failures++; $display("FAIL reset_bit_stb got=%b exp=0", BIT_STB); end
    checks++; if (BIT_OUT !== 1'b0)   begin failures++; $display("FAIL reset_bit_out got=%b exp=0", BIT_OUT); end
    checks++; if (RX_DONE !== 1'b0)   begin failures++; $display("FAIL reset_rx_done got=%b exp=0", RX_DONE); end
    checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", FRAME_ERR); end
    RST_N = 1'b1;
    hold_ticks(8);
    checks++; if (BUSY !== 1'b0)      begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", BUSY); end
    $display("reset: done");
  endtask

  task automatic test_frame_a5;
    int base, d0, e0, n;
    logic [7:0] b;
    base = got_bits.size(); d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    hold_ticks(4);
    n = got_bits.size() - base;
    b = '0;
    for (int i = 0; i < DB; i++) if (base + i < got_bits.size()) b[i] = got_bits[base + i];
    checks++; if (n !== DB)               begin failures++; $display("FAIL a5_strobes got=%0d exp=%0d", n, DB); end
    checks++; if (b !== 8'hA5)            begin failures++; $display("FAIL a5_data got=%h exp=a5", b); end
    checks++; if (done_cnt - d0 !== 1)    begin failures++; $display("FAIL a5_rx_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0)     begin failures++; $display("FAIL a5_frame_err got=%0d exp=0", err_cnt - e0); end
    checks++; if (BUSY !== 1'b0)          begin failures++; $display("FAIL a5_busy got=%b exp=0", BUSY); end
    $display("frame 0xA5: strobes=%0d data=%h", n, b);
  endtask

  task automatic test_false_start;
    int base, d0, e0;
    base = got_bits.size(); d0 = done_cnt; e0 = err_cnt;
    RX = 1'b0;
    hold_ticks(4);
    RX = 1'b1;
    hold_ticks(2);
    checks++; if (BUSY !== 1'b1)          begin failures++; $display("FAIL false_start_busy_tick6 got=%b exp=1", BUSY); end
    hold_ticks(4);
    checks++; if (BUSY !== 1'b0)          begin failures++; $display("FAIL false_start_busy_tick10 got=%b exp=0", BUSY); end
    hold_ticks(16);
    checks++; if (got_bits.size() != base) begin failures++; $display("FAIL false_start_strobes got=%0d exp=0", got_bits.size() - base); end
    checks++; if (done_cnt - d0 + err_cnt - e0 !== 0) begin failures++; $display("FAIL false_start_pulses got=%0d exp=0", done_cnt - d0 + err_cnt - e0); end
    $display("false start: done");
  endtask

  task automatic test_frame_err;
    int base, d0, e0, n, b0, busy0;
    logic [7:0] b;
    base = got_bits.size(); d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    hold_ticks(2);
    n = got_bits.size() - base;
    b = '0;
    for (int i = 0; i < DB; i++) if (base + i < got_bits.size()) b[i] = got_bits[base + i];
    checks++; if (n !== DB)               begin failures++; $display("FAIL ferr_strobes got=%0d exp=%0d", n, DB); end
    checks++; if (b !== 8'h3C)            begin failures++; $display("FAIL ferr_data got=%h exp=3c", b); end
    checks++; if (err_cnt - e0 !== 1)     begin failures++; $display("FAIL ferr_frame_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0)    begin failures++; $display("FAIL ferr_rx_done got=%0d exp=0", done_cnt - d0); end
    b0 = got_bits.size(); busy0 = busy_cyc;
    hold_ticks(40);
    checks++; if (busy_cyc != busy0)      begin failures++; $display("FAIL ferr_low_busy_cycles got=%0d exp=0", busy_cyc - busy0); end
    checks++; if (got_bits.size() != b0)  begin failures++; $display("FAIL ferr_low_strobes got=%0d exp=0", got_bits.size() - b0); end
    RX = 1'b1;
    hold_ticks(16);
    $display("frame 0x3C stop=0: strobes=%0d data=%h", n, b);
  endtask

  task automatic test_reset_mid;
    logic [7:0] data;
    int base, d0, e0, n;
    logic [7:0] b;
    data = 8'h0F;
    d0 = done_cnt; e0 = err_cnt;
    RX = 1'b0;
    hold_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      RX = data[i];
      hold_ticks(OS);
    end
    RX = data[3];
    hold_ticks(8);
    RST_N = 1'b0;
    RX    = 1'b1;
    @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0)      begin failures++; $display("FAIL rstmid_busy got=%b exp=0", BUSY); end
    checks++; if (BIT_STB !== 1'b0)   begin failures++; $display("FAIL rstmid_bit_stb got=%b exp=0", BIT_STB); end
    checks++; if (BIT_OUT !== 1'b0)   begin failures++; $display("FAIL rstmid_bit_out got=%b exp=0", BIT_OUT); end
    checks++; if (RX_DONE !== 1'b0)   begin failures++; $display("FAIL rstmid_rx_done got=%b exp=0", RX_DONE); end
    checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL rstmid_frame_err got=%b exp=0", FRAME_ERR); end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    base = got_bits.size();
    hold_ticks(32);
    checks++; if (got_bits.size() != base) begin failures++; $display("FAIL rstmid_strobes_after got=%0d exp=0", got_bits.size() - base); end
    checks++; if (done_cnt - d0 + err_cnt - e0 !== 0) begin failures++; $display("FAIL rstmid_pulses got=%0d exp=0", done_cnt - d0 + err_cnt - e0); end
    send_frame(8'h5A, 1'b1, 1'b1);
    hold_ticks(4);
    n = got_bits.size() - base;
    b = '0;
    for (int i = 0; i < DB; i++) if (base + i < got_bits.size()) b[i] = got_bits[base + i];
    checks++; if (n !== DB)               begin failures++; $display("FAIL rstmid_5a_strobes got=%0d exp=%0d", n, DB); end
    checks++; if (b !== 8'h5A)            begin failures++; $display("FAIL rstmid_5a_data got=%h exp=5a", b); end
    checks++; if (done_cnt - d0 !== 1)    begin failures++; $display("FAIL rstmid_5a_rx_done got=%0d exp=1", done_cnt - d0); end
    $display("reset mid-frame then 0x5A: data=%h", b);
  endtask

  task automatic test_back_to_back;
    int base, d0, n, bad;
    base = got_bits.size(); d0 = done_cnt;
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h00, 1'b1, 1'b1);
    hold_ticks(4);
    n = got_bits.size() - base;
    bad = 0;
    for (int i = 0; i < 2 * DB; i++)
      if (base + i < got_bits.size() && got_bits[base + i] !== (i < DB)) bad++;
    checks++; if (n !== 2 * DB)           begin failures++; $display("FAIL b2b_strobes got=%0d exp=%0d", n, 2 * DB); end
    checks++; if (bad !== 0)              begin failures++; $display("FAIL b2b_bits wrong_bits=%0d exp=0", bad); end
    checks++; if (done_cnt - d0 !== 2)    begin failures++; $display("FAIL b2b_rx_done got=%0d exp=2", done_cnt - d0); end
    checks++; if (both_cnt !== 0)         begin failures++; $display("FAIL b2b_done_and_err got=%0d exp=0", both_cnt); end
    $display("back-to-back 0xFF,0x00: strobes=%0d", n);
  endtask

  task automatic test_tick_gate;
    int base, d0, n, n_frozen;
    logic busy_frozen;
    logic [7:0] b;
    base = got_bits.size(); d0 = done_cnt;
    n_frozen = 0; busy_frozen = 1'b0;
    fork
      send_frame(8'h69, 1'b1, 1'b1);
      begin
        hold_ticks(OS + 3 * OS + 8);
        tick_en = 1'b0;
        repeat (2) @(negedge CLK);
        n_frozen = got_bits.size();
        busy_frozen = 1'b1;
        repeat (98) begin
          @(negedge CLK);
          if (BUSY !== 1'b1) busy_frozen = 1'b0;
        end
        checks++; if (got_bits.size() != n_frozen) begin failures++; $display("FAIL gate_strobes_frozen got=%0d exp=0", got_bits.size() - n_frozen); end
        checks++; if (busy_frozen !== 1'b1)        begin failures++; $display("FAIL gate_busy_held got=%b exp=1", busy_frozen); end
        tick_en = 1'b1;
      end
    join
    hold_ticks(4);
    n = got_bits.size() - base;
    b = '0;
    for (int i = 0; i < DB; i++) if (base + i < got_bits.size()) b[i] = got_bits[base + i];
    checks++; if (n !== DB)               begin failures++; $display("FAIL gate_strobes got=%0d exp=%0d", n, DB); end
    checks++; if (b !== 8'h69)            begin failures++; $display("FAIL gate_data got=%h exp=69", b); end
    checks++; if (done_cnt - d0 !== 1)    begin failures++; $display("FAIL gate_rx_done got=%0d exp=1", done_cnt - d0); end
    $display("tick gating mid-frame 0x69: data=%h", b);
  endtask

  task automatic test_random;
    logic exp_bits[$];
    int base, d0, e0, exp_done, exp_err, bad, gap;
    logic [7:0] data;
    logic stop;
    base = got_bits.size(); d0 = done_cnt; e0 = err_cnt;
    exp_done = 0; exp_err = 0;
    for (int f = 0; f < 8; f++) begin
      data = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      gap  = stop ? $urandom_range(0, 6) : $urandom_range(2, 6);
      for (int i = 0; i < DB; i++) exp_bits.push_back(data[i]);
      if (stop) exp_done++; else exp_err++;
      send_frame(data, stop, 1'b1);
      hold_ticks(gap);
      $display("random frame %0d: data=%h stop=%b gap=%0d", f, data, stop, gap);
    end
    hold_ticks(4);
    bad = 0;
    for (int i = 0; i < exp_bits.size(); i++)
      if (base + i >= got_bits.size() || got_bits[base + i] !== exp_bits[i]) bad++;
    checks++; if (got_bits.size() - base != exp_bits.size()) begin failures++; $display("FAIL rand_strobes got=%0d exp=%0d", got_bits.size() - base, exp_bits.size()); end
    checks++; if (bad !== 0)                  begin failures++; $display("FAIL rand_bits wrong_bits=%0d exp=0", bad); end
    checks++; if (done_cnt - d0 !== exp_done) begin failures++; $display("FAIL rand_rx_done got=%0d exp=%0d", done_cnt - d0, exp_done); end
    checks++; if (err_cnt - e0 !== exp_err)   begin failures++; $display("FAIL rand_frame_err got=%0d exp=%0d", err_cnt - e0, exp_err); end
    checks++; if (both_cnt !== 0)             begin failures++; $display("FAIL rand_done_and_err got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    tick_en = 1'b1;
    RST_N   = 1'b0;
    RX      = 1'b1;
    test_reset;
    test_frame_a5;
    test_false_start;
    test_frame_err;
    test_reset_mid;
    test_back_to_back;
    test_tick_gate;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame (5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16: BAUD_TICK pulses per bit period (even, 8..32).
REQ-003 SHALL have port CLK  input  1  single clock; all logic on posedge CLK.
REQ-004 SHALL have port RST_N  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port BAUD_TICK  input  1  one-cycle enable, OVERSAMPLE pulses per bit.
REQ-006 SHALL have port RX  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port BIT_OUT  output  1  sampled data bit, valid while BIT_STB=1.
REQ-008 SHALL have port BIT_STB  output  1  one-cycle strobe per data bit; clock-enable for the downstream shift stage.
REQ-009 SHALL have port RX_DONE  output  1  one-cycle pulse: frame complete, stop bit high.
REQ-010 SHALL have port FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port BUSY  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL pass RX through a 2-flop synchronizer; all decisions use the synchronized value RXS; a registered copy RXS_D provides edge detection.
REQ-013 SHALL implement the states IDLE, START, DATA and STOP.
REQ-014 IDLE: on a cycle with RXS_D=1 and RXS=0 (falling edge), SHALL go to START and clear the tick counter; a line held low SHALL NOT retrigger.
REQ-015 Tick counter SHALL advance only on BAUD_TICK; with no BAUD_TICK, state and counters SHALL hold.
REQ-016 START: on the BAUD_TICK where the counter equals OVERSAMPLE/2-1, SHALL sample RXS; 0 -> go to DATA and clear the counter; 1 -> go to IDLE as a false start, with no output pulse.
REQ-017 DATA: on the BAUD_TICK where the counter equals OVERSAMPLE-1, SHALL sample RXS, clear the counter, and in the next cycle drive BIT_OUT=sample and BIT_STB=1 for exactly one cycle.
REQ-018 Data bits SHALL arrive LSB first; the bit counter SHALL run 0..DATA_BITS-1; the sample of bit DATA_BITS-1 SHALL move the FSM to STOP.
REQ-019 STOP: on the BAUD_TICK where the counter equals OVERSAMPLE-1, SHALL sample RXS; 1 -> RX_DONE pulse; 0 -> FRAME_ERR pulse; both cases go to IDLE; the pulse SHALL occur in the cycle after the sample.
REQ-020 RX_DONE and FRAME_ERR SHALL never be high in the same cycle.
REQ-021 After a FRAME_ERR, SHALL NOT start a new frame until RXS has returned high and a new falling edge occurs.
REQ-022 A falling edge arriving in the same cycle as the return to IDLE SHALL be detected, so back-to-back frames without extra idle time are supported.
REQ-023 Bit and tick counters SHALL be sized $clog2 of their maximum count and SHALL never wrap inside a state.
REQ-024 BIT_OUT SHALL hold its last value when BIT_STB=0.

Reset
REQ-025 While RST_N=0 at posedge CLK: state=IDLE, counters=0, BIT_OUT=0, BIT_STB=0, RX_DONE=0, FRAME_ERR=0, BUSY=0, both synchronizer flops=1 and RXS_D=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no RX_DONE or FRAME_ERR pulse; reception SHALL resume only on the next falling edge after reset is released.

Structure
REQ-027 The state enum (IDLE/START/DATA/STOP) and the OVERSAMPLE and DATA_BITS defaults SHALL live in package uart_pkg, shared with the TX side.
REQ-028 The 2-flop synchronizer SHALL be the sub-module rx_sync, with ports CLK, RST_N, D and Q, and reset value 1.
REQ-029 BIT_OUT and BIT_STB SHALL connect directly to the serial input and the clock-enable of the downstream shift register.

Verification (OVERSAMPLE=16, DATA_BITS=8, BAUD_TICK every 4 CLK)
REQ-030 Frame 0xA5 with stop=1 -> 8 BIT_STB pulses with BIT_OUT = 1,0,1,0,0,1,0,1, then exactly one RX_DONE, then BUSY=0.
REQ-031 RX low for 4 ticks, then high -> return to IDLE at tick 8, with no BIT_STB, RX_DONE or FRAME_ERR.
REQ-032 Frame 0x3C with stop=0 -> 8 BIT_STB pulses, one FRAME_ERR, no RX_DONE; then with RX held low for 40 ticks -> no new frame starts.
REQ-033 RST_N=0 for 2 cycles during data bit 3 -> all outputs 0 within 1 cycle, no pulse; a following frame 0x5A is received correctly.
REQ-034 Two back-to-back frames 0xFF then 0x00, with the start bit immediately after the stop bit -> 16 BIT_STB pulses and 2 RX_DONE pulses.
REQ-035 BAUD_TICK gated off for 100 cycles mid-DATA -> state and counters frozen, and the frame completes correctly once ticks resume.
